// File: rtl/fcpu_pkg.sv
// Shared CPU definitions used by the branch predictor: counter type, encodings, sizes.
package fcpu_pkg;

  localparam int unsigned CRAM_ADDR_W = 16;
  localparam int unsigned BP_IDX_W    = 6;

  typedef logic [1:0] bp_cnt_t;

  localparam bp_cnt_t BP_SNT = 2'd0;
  localparam bp_cnt_t BP_WNT = 2'd1;
  localparam bp_cnt_t BP_WT  = 2'd2;
  localparam bp_cnt_t BP_ST  = 2'd3;

  // Saturating 2-bit step toward the resolved outcome.
  function automatic bp_cnt_t bp_sat_next(input bp_cnt_t cnt, input logic taken);
    bp_cnt_t nxt;
    nxt = cnt;
    if (taken && (cnt != BP_ST)) begin
      nxt = cnt + 2'd1;
    end else if (!taken && (cnt != BP_SNT)) begin
      nxt = cnt - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_predictor_table.sv
// Flop array of 2-bit saturating counters: one write port, one read port with write-first bypass.
module bp_counter_table
  import fcpu_pkg::*;
#(
  parameter int unsigned IDX_W = BP_IDX_W
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [IDX_W-1:0] rd_idx_i,
  output bp_cnt_t          rd_cnt_c,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic             wr_taken_i
);

  localparam int unsigned DEPTH = 1 << IDX_W;

  bp_cnt_t cnt_q [DEPTH];
  bp_cnt_t wr_next_c;

  assign wr_next_c = bp_sat_next(cnt_q[wr_idx_i], wr_taken_i);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++) begin
        cnt_q[i] <= BP_WNT;
      end
    end else if (wr_en_i) begin
      cnt_q[wr_idx_i] <= wr_next_c;
    end
  end

  // A same-cycle write to the looked-up entry is visible to the read.
  assign rd_cnt_c = (wr_en_i && (wr_idx_i == rd_idx_i)) ? wr_next_c : cnt_q[rd_idx_i];

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch predictor feeding the scheduler take_flag, one cycle after the fetch handshake.
// Optional gshare indexing with a global history register when BP_GSHARE_EN is defined.
module branch_predictor
  import fcpu_pkg::*;
#(
  parameter int unsigned IDX_W  = BP_IDX_W,
  parameter int unsigned ADDR_W = CRAM_ADDR_W
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              ce,
  input  logic              clear,
  input  logic              lookup_valid,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              take_flag,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic              upd_predicted
);

  logic [IDX_W-1:0] lk_idx_c;
  logic [IDX_W-1:0] up_idx_c;
  bp_cnt_t          rd_cnt_c;
  logic             take_flag_q;
  logic             take_flag_d;

`ifdef BP_GSHARE_EN
  logic [IDX_W-1:0] ghr_q;
  logic [IDX_W-1:0] ghr_d;

  // History shifts on every resolution, independent of ce and clear.
  always_comb begin
    ghr_d = ghr_q;
    if (upd_valid) begin
      ghr_d = {ghr_q[IDX_W-2:0], upd_taken};
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end

  assign lk_idx_c = lookup_pc[IDX_W+1:2] ^ ghr_q;
  assign up_idx_c = upd_pc[IDX_W+1:2] ^ ghr_q;
`else
  assign lk_idx_c = lookup_pc[IDX_W+1:2];
  assign up_idx_c = upd_pc[IDX_W+1:2];
`endif

  bp_counter_table #(
    .IDX_W (IDX_W)
  ) u_table (
    .clk        (clk),
    .nrst       (nrst),
    .rd_idx_i   (lk_idx_c),
    .rd_cnt_c   (rd_cnt_c),
    .wr_en_i    (upd_valid),
    .wr_idx_i   (up_idx_c),
    .wr_taken_i (upd_taken)
  );

  // Flush wins over halt; halt holds the last prediction.
  always_comb begin
    take_flag_d = take_flag_q;
    if (clear) begin
      take_flag_d = 1'b0;
    end else if (ce) begin
      take_flag_d = lookup_valid & rd_cnt_c[1];
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      take_flag_q <= 1'b0;
    end else begin
      take_flag_q <= take_flag_d;
    end
  end

  assign take_flag = take_flag_q;

  // Aliased upper PC bits, byte offset and the stats-only input carry no function here.
  logic unused_c;
  assign unused_c = ^{upd_predicted, rd_cnt_c[0],
                      lookup_pc[ADDR_W-1:IDX_W+2], lookup_pc[1:0],
                      upd_pc[ADDR_W-1:IDX_W+2], upd_pc[1:0]};

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Bimodal branch predictor that produces the `take_flag` input of the instruction scheduler.
- Looks up a table of 2-bit saturating counters using the CRAM fetch address at the AR handshake.
- Presents the prediction one cycle later, aligned with the returning instruction word.
- Trained by the core on branch resolution; the table persists across pipeline flushes.

Parameters:
- IDX_W, 6, log2 of counter-table depth (64 entries); index = pc[IDX_W+1:2].
- ADDR_W, CRAM_ADDR_W, width of PC/address ports (from fcpu_pkg).

Ports:
- clk  in  1  clock.
- nrst  in  1  reset; one clock; reset is asynchronous and active-low.
- ce  in  1  pipeline enable (0 = halt; hold prediction output).
- clear  in  1  synchronous pipeline flush.
- lookup_valid  in  1  fetch request accepted this cycle (scheduler arvalid & arready).
- lookup_pc  in  ADDR_W  fetch address of that request.
- take_flag  out  1  prediction for the instruction returning this cycle.
- upd_valid  in  1  core resolved a conditional branch this cycle.
- upd_pc  in  ADDR_W  PC of the resolved branch.
- upd_taken  in  1  actual outcome.
- upd_predicted  in  1  prediction that was used (stats only).

Behaviour:
- Storage: 2^IDX_W entries of bp_cnt_t, held in flops.
- nrst low (async): every counter = BP_WNT (2'b01); take_flag = 0; all internal registers = 0.
- Prediction = counter[1].
- Lookup, 1-cycle latency:
  - Cycle N, ce=1, clear=0, lookup_valid=1: sample the predicted bit for idx(lookup_pc) into the take_flag register; take_flag shows it at N+1.
  - ce=1, clear=0, lookup_valid=0: take_flag = 0 at N+1.
  - ce=0: take_flag holds its value; lookup ignored.
  - clear=1 (priority over ce): take_flag = 0 next edge; table untouched.
- Update:
  - Applied on every edge with upd_valid=1, regardless of ce and clear.
  - upd_taken=1: counter increments, saturating at 3.
  - upd_taken=0: counter decrements, saturating at 0.
  - No wrap-around past 0 or 3 under any sequence.
- Simultaneous lookup and update:
  - Same index: lookup uses the post-update counter (write-first bypass).
  - Different indices: independent.
- Index arithmetic: pc bits [IDX_W+1:2] only. Upper bits alias; bits [1:0] are ignored.
- Reset asserted mid-operation: the table reverts to BP_WNT immediately (async); any in-flight update is lost.
- No backpressure: every lookup and update is accepted every cycle.

Optional Feature:
- Macro BP_GSHARE_EN.
- Defined:
  - Adds an IDX_W-bit global history register (GHR), reset 0.
  - Index = pc[IDX_W+1:2] ^ GHR for both lookup and update, using the GHR value of the current cycle.
  - On upd_valid, GHR <= {GHR[IDX_W-2:0], upd_taken} after the index is formed.
  - clear and ce do not affect GHR.
  - Bypass compares the final XORed indices.
- Undefined: pure bimodal indexing; no GHR flops.
- upd_predicted is unused in both modes unless the statistics counters are implemented.

Decomposition:
- fcpu_pkg additions:
  - typedef bp_cnt_t (logic [1:0]).
  - Constants BP_SNT=0, BP_WNT=1, BP_WT=2, BP_ST=3.
  - BP_IDX_W default 6.
  - Function bp_sat_next(bp_cnt_t, logic taken).
- Sub-module bp_counter_table:
  - Flop array with async reset.
  - One read port with write-first bypass and one write port.
- branch_predictor holds the index logic, the optional GHR and the output register.

Test Plan:
- Reset release, lookup_valid=1 at pc=0x0010 → take_flag=0 next cycle (counter 01).
- Two updates pc=0x0010 taken, then lookup 0x0010 → take_flag=1. A third taken keeps the counter at 3; four not-taken → counter 0. A fifth not-taken stays at 0 and the lookup returns 0.
- Same cycle: upd_valid pc=0x0020 taken (counter 01→10) and lookup pc=0x0020 → take_flag=1 next cycle (bypass).
- take_flag=1 then ce=0 for 3 cycles with lookups toggling → take_flag stays 1. Then clear=1 → take_flag=0, and a later lookup of the same pc still returns 1 (table retained).
- Aliasing: train pc=0x0010 taken twice, lookup pc=0x0110 (IDX_W=6) → take_flag=1.
- BP_GSHARE_EN:
  - Three taken updates at pc=0x0000 → GHR=3'b111 in low bits.
  - Lookup pc=0x001C (idx 7) reads entry 7^7=0 → take_flag=1.
  - Assert nrst low mid-sequence → GHR=0, all entries 01.
